// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the 5-stage pipeline hazard controller.
// Result-select encodings, forwarding selects and controller states.
package pipe_ctrl_pkg;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_ME   = 2'b10;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle: stage register/reg-file tags in, stall/flush/forward controls out.
// The master side is the controller; the slave side is the pipeline datapath.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 32
);

   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic [4:0]       ex_rs1;
   logic [4:0]       ex_rs2;
   logic [4:0]       ex_rd;
   logic             ex_reg_write;
   logic [1:0]       ex_result_sel;
   logic             ex_branch_taken;
   logic [4:0]       me_rd;
   logic [4:0]       wb_rd;
   logic             me_reg_write;
   logic             wb_reg_write;
   logic             me_mem_req;
   logic             dmem_ready;

   logic             stall_pc;
   logic             stall_if_id;
   logic             stall_id_ex;
   logic             stall_ex_me;
   logic             stall_me_wb;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic             mem_error;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_result_sel,
             ex_branch_taken, me_rd, wb_rd, me_reg_write, wb_reg_write,
             me_mem_req, dmem_ready,
      output stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb,
             flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, mem_error, stall_cycles
   );

   modport slave (
      output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_result_sel,
             ex_branch_taken, me_rd, wb_rd, me_reg_write, wb_reg_write,
             me_mem_req, dmem_ready,
      input  stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb,
             flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel, mem_error, stall_cycles
   );

endinterface

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source register.
// The younger ME result takes precedence over WB; x0 is never forwarded.
module fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] ex_rs_i,
   input  logic [4:0] me_rd_i,
   input  logic       me_we_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_we_i,
   output logic [1:0] sel_o
);

   always_comb begin
      sel_o = FWD_NONE;
      if (me_we_i && (me_rd_i != 5'd0) && (me_rd_i == ex_rs_i)) begin
         sel_o = FWD_ME;
      end else if (wb_we_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use bubble, branch flush,
// data-memory wait with timeout abort, operand forwarding and a saturating stall counter.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic           clk,
   input  logic           rst,
   pipeline_ctrl_if.master bus
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   pc_state_t        state_q, state_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic             mem_error_q, mem_error_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb;
   logic             flush_if_id, flush_id_ex;
   logic             load_use;
   logic [1:0]       fwd_a_raw, fwd_b_raw;

   fwd_unit u_fwd_a (
      .ex_rs_i (bus.ex_rs1),
      .me_rd_i (bus.me_rd),
      .me_we_i (bus.me_reg_write),
      .wb_rd_i (bus.wb_rd),
      .wb_we_i (bus.wb_reg_write),
      .sel_o   (fwd_a_raw)
   );

   fwd_unit u_fwd_b (
      .ex_rs_i (bus.ex_rs2),
      .me_rd_i (bus.me_rd),
      .me_we_i (bus.me_reg_write),
      .wb_rd_i (bus.wb_rd),
      .wb_we_i (bus.wb_reg_write),
      .sel_o   (fwd_b_raw)
   );

   assign load_use = bus.ex_reg_write && (bus.ex_result_sel == RES_MEM) &&
                     (bus.ex_rd != 5'd0) &&
                     ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

   // While waiting on memory the whole pipe is frozen, so branch and load-use
   // decisions are deferred until the held instructions are re-examined in RUN.
   always_comb begin
      state_d     = state_q;
      tcnt_d      = tcnt_q;
      mem_error_d = 1'b0;
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      stall_id_ex = 1'b0;
      stall_ex_me = 1'b0;
      stall_me_wb = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;

      if (rst) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
         state_d     = RUN;
         tcnt_d      = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.me_mem_req && !bus.dmem_ready) begin
                  stall_pc    = 1'b1;
                  stall_if_id = 1'b1;
                  stall_id_ex = 1'b1;
                  stall_ex_me = 1'b1;
                  stall_me_wb = 1'b1;
                  state_d     = MEM_WAIT;
                  tcnt_d      = TW'(1);
               end else if (bus.ex_branch_taken) begin
                  flush_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end else if (load_use) begin
                  stall_pc    = 1'b1;
                  stall_if_id = 1'b1;
                  flush_id_ex = 1'b1;
               end
            end
            MEM_WAIT: begin
               stall_pc    = 1'b1;
               stall_if_id = 1'b1;
               stall_id_ex = 1'b1;
               stall_ex_me = 1'b1;
               stall_me_wb = 1'b1;
               if (bus.dmem_ready) begin
                  state_d = RUN;
                  tcnt_d  = '0;
               end else if (tcnt_q == TW'(MEM_TIMEOUT)) begin
                  mem_error_d = 1'b1;
                  state_d     = RUN;
                  tcnt_d      = '0;
               end else begin
                  tcnt_d = tcnt_q + TW'(1);
               end
            end
            default: begin
               state_d = RUN;
               tcnt_d  = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         tcnt_q      <= '0;
         mem_error_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         mem_error_q <= mem_error_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.stall_pc     = stall_pc;
   assign bus.stall_if_id  = stall_if_id;
   assign bus.stall_id_ex  = stall_id_ex;
   assign bus.stall_ex_me  = stall_ex_me;
   assign bus.stall_me_wb  = stall_me_wb;
   assign bus.flush_if_id  = flush_if_id;
   assign bus.flush_id_ex  = flush_id_ex;
   assign bus.fwd_a_sel    = rst ? FWD_NONE : fwd_a_raw;
   assign bus.fwd_b_sel    = rst ? FWD_NONE : fwd_b_raw;
   assign bus.mem_error    = mem_error_q;
   assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: each applied vector queues its expected
// outputs, and an independent monitor compares them against the DUT once per cycle.
module tb_pipeline_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;

   localparam logic [4:0] ST_NONE = 5'b00000;
   localparam logic [4:0] ST_ALL  = 5'b11111;
   localparam logic [4:0] ST_LU   = 5'b11000;

   logic clk = 1'b0;
   logic rst;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [4:0] id_rs1;
      logic [4:0] id_rs2;
      logic [4:0] ex_rs1;
      logic [4:0] ex_rs2;
      logic [4:0] ex_rd;
      logic       ex_we;
      logic [1:0] ex_sel;
      logic       br;
      logic [4:0] me_rd;
      logic       me_we;
      logic [4:0] wb_rd;
      logic       wb_we;
      logic       req;
      logic       ready;
   } stim_t;

   typedef struct packed {
      logic [4:0]       st;
      logic [1:0]       fl;
      logic [1:0]       fa;
      logic [1:0]       fb;
      logic             err;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   stim_t            nx;
   exp_t             expQ[$];
   string            nameQ[$];
   int               assertCount = 0;
   int               failCount   = 0;
   logic [CNT_W-1:0] modelCnt    = '0;

   task automatic driveInputs(input stim_t s);
      rst                 = s.rst;
      bus.id_rs1          = s.id_rs1;
      bus.id_rs2          = s.id_rs2;
      bus.ex_rs1          = s.ex_rs1;
      bus.ex_rs2          = s.ex_rs2;
      bus.ex_rd           = s.ex_rd;
      bus.ex_reg_write    = s.ex_we;
      bus.ex_result_sel   = s.ex_sel;
      bus.ex_branch_taken = s.br;
      bus.me_rd           = s.me_rd;
      bus.me_reg_write    = s.me_we;
      bus.wb_rd           = s.wb_rd;
      bus.wb_reg_write    = s.wb_we;
      bus.me_mem_req      = s.req;
      bus.dmem_ready      = s.ready;
   endtask

   // One vector per cycle: inputs change on the falling edge, expected outputs are queued,
   // and the stall counter expectation follows from the stall_pc values already queued.
   task automatic applyStimulus(input string name, input logic [4:0] st, input logic [1:0] fl,
                                input logic [1:0] fa, input logic [1:0] fb, input logic err);
      exp_t e;
      @(negedge clk);
      driveInputs(nx);
      e.st  = st;
      e.fl  = fl;
      e.fa  = fa;
      e.fb  = fb;
      e.err = err;
      e.cnt = modelCnt;
      expQ.push_back(e);
      nameQ.push_back(name);
      if (nx.rst) begin
         modelCnt = '0;
      end else if (st[4] && (modelCnt != {CNT_W{1'b1}})) begin
         modelCnt = modelCnt + 1'b1;
      end
   endtask

   task automatic checkOutput();
      exp_t  e;
      exp_t  a;
      string n;
      e     = expQ.pop_front();
      n     = nameQ.pop_front();
      a.st  = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex, bus.stall_ex_me, bus.stall_me_wb};
      a.fl  = {bus.flush_if_id, bus.flush_id_ex};
      a.fa  = bus.fwd_a_sel;
      a.fb  = bus.fwd_b_sel;
      a.err = bus.mem_error;
      a.cnt = bus.stall_cycles;
      assertCount++;
      if (a !== e) begin
         failCount++;
         $display("[TB] FAIL %s: got st=%b fl=%b fa=%b fb=%b err=%b cnt=%0d, want st=%b fl=%b fa=%b fb=%b err=%b cnt=%0d",
                  n, a.st, a.fl, a.fa, a.fb, a.err, a.cnt, e.st, e.fl, e.fa, e.fb, e.err, e.cnt);
      end
   endtask

   always @(negedge clk) begin
      #2;
      if (expQ.size() != 0) checkOutput();
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      nx     = '0;
      nx.rst = 1'b1;
      driveInputs(nx);

      // Reset: flushes asserted, forwarding suppressed even with a matching ME write
      applyStimulus("reset_idle", ST_NONE, 2'b11, FWD_NONE, FWD_NONE, 1'b0);
      nx.me_rd = 5'd5; nx.me_we = 1'b1; nx.ex_rs1 = 5'd5;
      applyStimulus("reset_fwd_gated", ST_NONE, 2'b11, FWD_NONE, FWD_NONE, 1'b0);

      nx = '0;
      nx.me_rd = 5'd5; nx.me_we = 1'b1; nx.wb_rd = 5'd5; nx.wb_we = 1'b1;
      nx.ex_rs1 = 5'd5; nx.ex_rs2 = 5'd5;
      applyStimulus("fwd_me_wins", ST_NONE, 2'b00, FWD_ME, FWD_ME, 1'b0);
      nx.me_rd = 5'd7;
      applyStimulus("fwd_wb_only", ST_NONE, 2'b00, FWD_WB, FWD_WB, 1'b0);
      nx.me_rd = 5'd0; nx.wb_rd = 5'd0; nx.ex_rs1 = 5'd0; nx.ex_rs2 = 5'd0;
      applyStimulus("fwd_x0_never", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.me_rd = 5'd5; nx.me_we = 1'b0; nx.wb_rd = 5'd6; nx.ex_rs1 = 5'd5; nx.ex_rs2 = 5'd6;
      applyStimulus("fwd_me_we_low", ST_NONE, 2'b00, FWD_NONE, FWD_WB, 1'b0);

      nx = '0;
      nx.ex_rd = 5'd3; nx.ex_we = 1'b1; nx.ex_sel = RES_MEM; nx.id_rs2 = 5'd3;
      applyStimulus("load_use_rs2", ST_LU, 2'b01, FWD_NONE, FWD_NONE, 1'b0);
      nx.ex_rd = 5'd0; nx.ex_we = 1'b0; nx.ex_sel = RES_ALU;
      applyStimulus("load_use_cleared", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.ex_we = 1'b1; nx.ex_sel = RES_MEM; nx.id_rs1 = 5'd0; nx.id_rs2 = 5'd0;
      applyStimulus("load_x0_no_stall", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.ex_rd = 5'd3; nx.ex_sel = RES_ALU; nx.id_rs1 = 5'd3;
      applyStimulus("alu_no_stall", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.ex_sel = RES_MEM; nx.br = 1'b1;
      applyStimulus("branch_over_load_use", ST_NONE, 2'b11, FWD_NONE, FWD_NONE, 1'b0);

      // Memory wait released by dmem_ready; branch and load-use ignored while waiting
      nx = '0;
      nx.req = 1'b1;
      applyStimulus("mem_enter", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.br = 1'b1;
      applyStimulus("mem_wait_branch", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.br = 1'b0; nx.ex_rd = 5'd3; nx.ex_we = 1'b1; nx.ex_sel = RES_MEM; nx.id_rs1 = 5'd3;
      applyStimulus("mem_wait_load_use", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx = '0; nx.req = 1'b1; nx.ready = 1'b1;
      applyStimulus("mem_ready", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx = '0;
      applyStimulus("mem_back_run", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.req = 1'b1; nx.ready = 1'b1;
      applyStimulus("mem_hit_no_stall", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);

      // Timeout: one RUN stall plus MEM_TIMEOUT waiting cycles, then a single error pulse
      nx.ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         applyStimulus("timeout_stall", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      end
      nx.req = 1'b0;
      applyStimulus("timeout_error", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b1);
      applyStimulus("timeout_pulse_end", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);

      // Reset in the middle of a memory wait
      nx.req = 1'b1; nx.br = 1'b1;
      applyStimulus("mem_over_branch", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.br = 1'b0;
      applyStimulus("wait_before_reset", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
      nx.rst = 1'b1;
      applyStimulus("reset_in_wait", ST_NONE, 2'b11, FWD_NONE, FWD_NONE, 1'b0);
      nx = '0;
      applyStimulus("after_reset_run", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);

      // Push the stall counter past its maximum to show it holds at all-ones
      for (int k = 0; k < 4; k++) begin
         nx.req = 1'b1;
         for (int c = 0; c < 5; c++) begin
            applyStimulus("sat_stall", ST_ALL, 2'b00, FWD_NONE, FWD_NONE, 1'b0);
         end
         nx.req = 1'b0;
         applyStimulus("sat_abort", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b1);
      end
      applyStimulus("sat_hold", ST_NONE, 2'b00, FWD_NONE, FWD_NONE, 1'b0);

      repeat (3) @(negedge clk);
      #4;
      assertCount++;
      if (expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", expQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
